// File: rtl/sram_cell_arbiter.sv
// sram_cell_arbiter: shares one single-port synchronous memory cell between
// NUM_REQ requesters. Round-robin arbitration grants in the same cycle, read
// data is steered back one cycle later with a one-hot valid.
// Optional feature: define SRAM_ARB_LOCK_EN to let a winner hold the grant
// through rq_lock_list; without it rq_lock_list is ignored.
module sram_cell_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int BW_INDEX    = 13,
  parameter int CELL_WIDTH  = 128,
  parameter int BW_BYTE_WEN = 16
) (
  input  logic                            clk,
  input  logic                            rstnn,
  input  logic [NUM_REQ-1:0]              rq_req_list,
  input  logic [NUM_REQ-1:0]              rq_wenable_list,
  input  logic [BW_INDEX*NUM_REQ-1:0]     rq_index_list,
  input  logic [BW_BYTE_WEN*NUM_REQ-1:0]  rq_wpermit_list,
  input  logic [CELL_WIDTH*NUM_REQ-1:0]   rq_wdata_list,
  input  logic [NUM_REQ-1:0]              rq_lock_list,
  output logic [NUM_REQ-1:0]              rq_grant_list,
  output logic [NUM_REQ-1:0]              rq_rvalid_list,
  output logic [CELL_WIDTH-1:0]           rq_rdata,
  output logic [BW_INDEX-1:0]             cell_index,
  output logic                            cell_wenable,
  output logic [BW_BYTE_WEN-1:0]          cell_wpermit,
  output logic [CELL_WIDTH-1:0]           cell_wdata,
  output logic                            cell_renable,
  input  logic [CELL_WIDTH-1:0]           cell_rdata
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Last-grant pointer and one-hot read-pending register.
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;

  // Round-robin candidate and the final selection (lock may override).
  logic               rr_valid;
  logic [PTR_W-1:0]   rr_idx;
  logic               sel_valid;
  logic [PTR_W-1:0]   sel_idx;
  logic               active;

  // Round-robin search starting one past the last winner.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    int cand;
    rr_valid = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(ptr_q) + off) % NUM_REQ;
      if (!rr_valid && rq_req_list[cand]) begin
        rr_valid = 1'b1;
        rr_idx   = PTR_W'(cand);
      end
    end
  end

`ifdef SRAM_ARB_LOCK_EN
  logic             lock_q, lock_d;
  logic [PTR_W-1:0] owner_q, owner_d;

  // Lock owner keeps the grant while it holds both req and lock.
  always_comb begin
    if (lock_q && rq_req_list[owner_q] && rq_lock_list[owner_q]) begin
      sel_valid = 1'b1;
      sel_idx   = owner_q;
    end else begin
      sel_valid = rr_valid;
      sel_idx   = rr_idx;
    end
    lock_d  = active && rq_lock_list[sel_idx];
    owner_d = active ? sel_idx : owner_q;
  end

  // Lock state; cleared by reset.
  always_ff @(posedge clk or posedge rstnn) begin
    if (rstnn) begin
      lock_q  <= 1'b0;
      owner_q <= '0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^rq_lock_list;

  // Plain round-robin selection.
  always_comb begin
    sel_valid = rr_valid;
    sel_idx   = rr_idx;
  end
`endif

  // Grant, cell request mux and next-state for pointer and read return.
  always_comb begin
    active         = sel_valid && !rstnn;
    rq_grant_list  = '0;
    cell_index     = '0;
    cell_wpermit   = '0;
    cell_wdata     = '0;
    cell_wenable   = 1'b0;
    cell_renable   = 1'b0;
    ptr_d          = ptr_q;
    if (active) begin
      rq_grant_list[sel_idx] = 1'b1;
      cell_index   = rq_index_list[int'(sel_idx)*BW_INDEX +: BW_INDEX];
      cell_wpermit = rq_wpermit_list[int'(sel_idx)*BW_BYTE_WEN +: BW_BYTE_WEN];
      cell_wdata   = rq_wdata_list[int'(sel_idx)*CELL_WIDTH +: CELL_WIDTH];
      cell_wenable = rq_wenable_list[sel_idx];
      cell_renable = !rq_wenable_list[sel_idx];
      ptr_d        = sel_idx;
    end
    rvalid_d = cell_renable ? rq_grant_list : '0;
  end

  // Pointer and read-valid registers; reset gives requester 0 first priority.
  always_ff @(posedge clk or posedge rstnn) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rstnn) begin
      ptr_q    <= PTR_W'(NUM_REQ - 1);
      rvalid_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rq_rvalid_list = rvalid_q;
  assign rq_rdata       = cell_rdata;

endmodule
